// File: rtl/simplez_loader.sv
// simplez_loader: serial program loader for the Simplez core.
// Takes bytes from the UART receiver, assembles 12-bit words and writes them
// into the 512x12 program RAM. It holds the core in reset while a frame is
// loading and releases it only when the frame checksum is good.
//
// Frame: SYNC, LEN_H, LEN_L, N x (HI, LO), CSUM
//   N    = {LEN_H[0], LEN_L}, valid range 1..MAXWORDS
//   word = {HI[3:0], LO}
//   LEN_H + LEN_L + all HI/LO + CSUM must sum to 8'h00 (mod 256)
//
// Optional build macro: LOADER_ACK_EN adds a one-byte acknowledgement
// ('K' on success, 'E' on error/timeout) towards a UART transmitter.
//
// state  | meaning
// IDLE   | waiting for SYNC, all other bytes ignored
// LEN_H  | expecting high length byte (only bit 0 used)
// LEN_L  | expecting low length byte, range-check N
// DATA_H | expecting HI byte of the next word
// DATA_L | expecting LO byte, word written on the following cycle
// CSUM   | expecting checksum byte, frame ends here
module simplez_loader #(
  parameter logic [7:0]  SYNC     = 8'hA5,
  parameter logic [23:0] TIMEOUT  = 24'd1200000,
  parameter bit          AUTORUN  = 1'b1,
  parameter logic [8:0]  MAXWORDS = 9'd504
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_rcv,
  input  logic [7:0]  rx_data,
`ifdef LOADER_ACK_EN
  input  logic        tx_ready,
  output logic [7:0]  ack_data,
  output logic        ack_start,
`endif
  output logic [8:0]  mem_addr,
  output logic [11:0] mem_din,
  output logic        mem_we,
  output logic        cpu_rstn,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_H,
    S_LEN_L,
    S_DATA_H,
    S_DATA_L,
    S_CSUM
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  sum_q, sum_d;
  logic        len_h_q, len_h_d;
  logic [8:0]  n_q, n_d;
  logic [8:0]  idx_q, idx_d;
  logic [3:0]  hi_q, hi_d;
  logic [23:0] cnt_q, cnt_d;
  logic        boot_q, boot_d;
  logic [8:0]  mem_addr_q, mem_addr_d;
  logic [11:0] mem_din_q, mem_din_d;
  logic        mem_we_q, mem_we_d;
  logic        cpu_rstn_q, cpu_rstn_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        frame_end;
  logic        frame_ok;
  logic        timeout;
  logic [7:0]  sum_next;
  logic [8:0]  len_w;

`ifdef LOADER_ACK_EN
  logic        ack_pend_q, ack_pend_d;
  logic [7:0]  ack_val_q, ack_val_d;
  logic [7:0]  ack_data_q, ack_data_d;
  logic        ack_start_q, ack_start_d;
`endif

  assign sum_next = sum_q + rx_data;
  assign len_w    = {len_h_q, rx_data};
  // A byte arriving on the terminal-count cycle takes priority over the timeout.
  assign timeout  = !rx_rcv && (state_q != S_IDLE) && (cnt_q == 24'd1);

  // Next-state, byte handling, gap timer and registered-output computation.
  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    len_h_d    = len_h_q;
    n_d        = n_q;
    idx_d      = idx_q;
    hi_d       = hi_q;
    cnt_d      = cnt_q;
    boot_d     = 1'b1;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_we_d   = 1'b0;
    // First cycle out of reset picks the power-on run policy.
    cpu_rstn_d = boot_q ? cpu_rstn_q : AUTORUN;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    frame_end  = 1'b0;
    frame_ok   = 1'b0;

    if (rx_rcv) begin
      cnt_d = TIMEOUT;
    end else if ((state_q != S_IDLE) && (cnt_q != 24'd0)) begin
      cnt_d = cnt_q - 24'd1;
    end

    if (rx_rcv) begin
      case (state_q)
        S_IDLE: begin
          if (rx_data == SYNC) begin
            err_d      = 1'b0;
            busy_d     = 1'b1;
            cpu_rstn_d = 1'b0;
            sum_d      = 8'h00;
            idx_d      = 9'd0;
            state_d    = S_LEN_H;
          end
        end
        S_LEN_H: begin
          len_h_d = rx_data[0];
          sum_d   = sum_next;
          state_d = S_LEN_L;
        end
        S_LEN_L: begin
          sum_d = sum_next;
          if ((len_w != 9'd0) && (len_w <= MAXWORDS)) begin
            n_d     = len_w;
            state_d = S_DATA_H;
          end else begin
            err_d     = 1'b1;
            busy_d    = 1'b0;
            frame_end = 1'b1;
            state_d   = S_IDLE;
          end
        end
        S_DATA_H: begin
          hi_d    = rx_data[3:0];
          sum_d   = sum_next;
          state_d = S_DATA_L;
        end
        S_DATA_L: begin
          sum_d      = sum_next;
          mem_we_d   = 1'b1;
          mem_addr_d = idx_q;
          mem_din_d  = {hi_q, rx_data};
          idx_d      = idx_q + 9'd1;
          state_d    = (idx_q == n_q - 9'd1) ? S_CSUM : S_DATA_H;
        end
        S_CSUM: begin
          if (sum_next == 8'h00) begin
            done_d     = 1'b1;
            cpu_rstn_d = 1'b1;
            frame_ok   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          busy_d    = 1'b0;
          frame_end = 1'b1;
          state_d   = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (timeout) begin
      // RAM is partially written, so the core stays in reset.
      err_d     = 1'b1;
      busy_d    = 1'b0;
      frame_end = 1'b1;
      state_d   = S_IDLE;
    end

`ifdef LOADER_ACK_EN
    ack_pend_d  = ack_pend_q;
    ack_val_d   = ack_val_q;
    ack_data_d  = ack_data_q;
    ack_start_d = 1'b0;
    if (ack_pend_q && tx_ready) begin
      ack_start_d = 1'b1;
      ack_data_d  = ack_val_q;
      ack_pend_d  = 1'b0;
    end
    // A fresh result replaces anything still waiting for the transmitter.
    if (frame_end) begin
      ack_pend_d = 1'b1;
      ack_val_d  = frame_ok ? 8'h4B : 8'h45;
    end
`endif
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      sum_q      <= 8'h00;
      len_h_q    <= 1'b0;
      n_q        <= 9'd0;
      idx_q      <= 9'd0;
      hi_q       <= 4'h0;
      cnt_q      <= 24'd0;
      boot_q     <= 1'b0;
      mem_addr_q <= 9'd0;
      mem_din_q  <= 12'h000;
      mem_we_q   <= 1'b0;
      cpu_rstn_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef LOADER_ACK_EN
      ack_pend_q  <= 1'b0;
      ack_val_q   <= 8'h00;
      ack_data_q  <= 8'h00;
      ack_start_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      len_h_q    <= len_h_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      hi_q       <= hi_d;
      cnt_q      <= cnt_d;
      boot_q     <= boot_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_we_q   <= mem_we_d;
      cpu_rstn_q <= cpu_rstn_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef LOADER_ACK_EN
      ack_pend_q  <= ack_pend_d;
      ack_val_q   <= ack_val_d;
      ack_data_q  <= ack_data_d;
      ack_start_q <= ack_start_d;
`endif
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign mem_we   = mem_we_q;
  assign cpu_rstn = cpu_rstn_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
`ifdef LOADER_ACK_EN
  assign ack_data  = ack_data_q;
  assign ack_start = ack_start_q;
`endif

endmodule

// File: tb/tb_simplez_loader.sv
// Testbench for simplez_loader (TIMEOUT shortened to 100 cycles).
// RAM writes are checked against a scoreboard of expected address, data and
// cycle, filled as each LO byte is driven.
module tb_simplez_loader;

  localparam logic [23:0] TB_TIMEOUT = 24'd100;

  logic        clk;
  logic        rstn;
  logic        rx_rcv;
  logic [7:0]  rx_data;
  logic [8:0]  mem_addr;
  logic [11:0] mem_din;
  logic        mem_we;
  logic        cpu_rstn;
  logic        busy;
  logic        done;
  logic        err;
`ifdef LOADER_ACK_EN
  logic        tx_ready;
  logic [7:0]  ack_data;
  logic        ack_start;
`endif

  typedef struct {
    logic [8:0]  addr;
    logic [11:0] data;
    int          cyc;
  } wr_t;

  wr_t        exp_q[$];
  int         errors;
  int         checks;
  int         cyc;
  logic [7:0] tsum;

  simplez_loader #(
    .SYNC     (8'hA5),
    .TIMEOUT  (TB_TIMEOUT),
    .AUTORUN  (1'b1),
    .MAXWORDS (9'd504)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .rx_rcv   (rx_rcv),
    .rx_data  (rx_data),
`ifdef LOADER_ACK_EN
    .tx_ready (tx_ready),
    .ack_data (ack_data),
    .ack_start(ack_start),
`endif
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_we   (mem_we),
    .cpu_rstn (cpu_rstn),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Advance one clock; sample #1 after the edge and retire any RAM write.
  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (rstn && mem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected addr=%0h din=%0h cyc=%0d", mem_addr, mem_din, cyc);
      end else begin
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_din !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL write addr=%0h din=%0h cyc=%0d expected addr=%0h din=%0h cyc=%0d",
                   mem_addr, mem_din, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_rcv  = 1'b1;
    rx_data = b;
    tsum    = tsum + b;
    tick();
    rx_rcv  = 1'b0;
  endtask

  // Sends one word; the write must appear on the tick that samples LO.
  task automatic send_word(input logic [8:0] addr, input logic [7:0] hi, input logic [7:0] lo);
    wr_t e;
    send_byte(hi);
    e.addr = addr;
    e.data = {hi[3:0], lo};
    e.cyc  = cyc + 1;
    exp_q.push_back(e);
    send_byte(lo);
  endtask

  task automatic send_sync();
    send_byte(8'hA5);
    tsum = 8'h00;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing_writes got=%0d pending expected=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) tick();
    checks++;
    if ({mem_addr, mem_din, mem_we, busy, done, err, cpu_rstn} !== 26'd0) begin
      errors++;
      $display("FAIL reset_values addr=%0h din=%0h we=%b busy=%b done=%b err=%b cpu_rstn=%b expected all 0",
               mem_addr, mem_din, mem_we, busy, done, err, cpu_rstn);
    end
    rstn = 1'b1;
    tick();
    checks++;
    if (cpu_rstn !== 1'b1 || busy !== 1'b0 || err !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL autorun cpu_rstn=%b busy=%b err=%b done=%b expected 1 0 0 0", cpu_rstn, busy, err, done);
    end
    repeat (5) tick();
    checks++;
    if (cpu_rstn !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold cpu_rstn=%b busy=%b expected 1 0", cpu_rstn, busy);
    end
  endtask

  task automatic good_frame(input string name);
    send_sync();
    checks++;
    if (cpu_rstn !== 1'b0 || busy !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL %s sync_accept cpu_rstn=%b busy=%b err=%b expected 0 1 0", name, cpu_rstn, busy, err);
    end
    send_byte(8'h00);
    send_byte(8'h03);
    send_word(9'd0, 8'h0A, 8'h05);
    send_word(9'd1, 8'h02, 8'h00);
    send_word(9'd2, 8'h0E, 8'h00);
    send_byte(8'h00 - tsum);
    checks++;
    if (done !== 1'b1 || cpu_rstn !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL %s end done=%b cpu_rstn=%b busy=%b err=%b expected 1 1 0 0", name, done, cpu_rstn, busy, err);
    end
    tick();
    checks++;
    if (done !== 1'b0 || cpu_rstn !== 1'b1) begin
      errors++;
      $display("FAIL %s done_pulse done=%b cpu_rstn=%b expected 0 1", name, done, cpu_rstn);
    end
    check_drained(name);
  endtask

  task automatic test_good_frame();
    good_frame("good_frame");
  endtask

  task automatic test_bad_csum();
    send_sync();
    send_byte(8'h00);
    send_byte(8'h03);
    send_word(9'd0, 8'h0A, 8'h05);
    send_word(9'd1, 8'h02, 8'h00);
    send_word(9'd2, 8'h0E, 8'h00);
    send_byte(8'h01 - tsum);
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || cpu_rstn !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_csum err=%b done=%b cpu_rstn=%b busy=%b expected 1 0 0 0", err, done, cpu_rstn, busy);
    end
    repeat (3) tick();
    checks++;
    if (err !== 1'b1 || cpu_rstn !== 1'b0) begin
      errors++;
      $display("FAIL bad_csum_sticky err=%b cpu_rstn=%b expected 1 0", err, cpu_rstn);
    end
    check_drained("bad_csum");
    good_frame("recover");
  endtask

  task automatic test_bad_len();
    send_sync();
    send_byte(8'h00);
    send_byte(8'h00);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL len_zero err=%b busy=%b expected 1 0", err, busy);
    end
    send_byte(8'h00);
    checks++;
    if (busy !== 1'b0 || err !== 1'b1) begin
      errors++;
      $display("FAIL len_zero_ignore busy=%b err=%b expected 0 1", busy, err);
    end
    send_sync();
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL sync_clears_err err=%b busy=%b expected 0 1", err, busy);
    end
    send_byte(8'h01);
    send_byte(8'hF9);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || cpu_rstn !== 1'b0) begin
      errors++;
      $display("FAIL len_505 err=%b busy=%b cpu_rstn=%b expected 1 0 0", err, busy, cpu_rstn);
    end
    send_byte(8'h00);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL len_505_ignore busy=%b expected 0", busy);
    end
    check_drained("bad_len");
  endtask

  // Largest legal frame: 504 words filling 0x000..0x1F7.
  task automatic test_max_words();
    logic [11:0] w;
    send_sync();
    send_byte(8'h01);
    send_byte(8'hF8);
    for (int i = 0; i < 504; i++) begin
      w = 12'(i * 37 + 5);
      send_word(9'(i), {4'h0, w[11:8]}, w[7:0]);
    end
    send_byte(8'h00 - tsum);
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || cpu_rstn !== 1'b1) begin
      errors++;
      $display("FAIL max_words done=%b err=%b cpu_rstn=%b expected 1 0 1", done, err, cpu_rstn);
    end
    check_drained("max_words");
  endtask

  task automatic test_timeout();
    send_sync();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h01);
    repeat (99) tick();
    checks++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early busy=%b err=%b expected 1 0", busy, err);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || err !== 1'b1 || cpu_rstn !== 1'b0) begin
      errors++;
      $display("FAIL timeout busy=%b err=%b cpu_rstn=%b expected 0 1 0", busy, err, cpu_rstn);
    end
    check_drained("timeout");
  endtask

  // Byte landing exactly on the terminal count keeps the frame alive.
  task automatic test_byte_wins();
    send_sync();
    send_byte(8'h00);
    send_byte(8'h01);
    repeat (99) tick();
    send_word(9'd0, 8'h12, 8'h34);
    checks++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL byte_wins busy=%b err=%b expected 1 0", busy, err);
    end
    send_byte(8'h00 - tsum);
    checks++;
    if (done !== 1'b1 || cpu_rstn !== 1'b1) begin
      errors++;
      $display("FAIL byte_wins_end done=%b cpu_rstn=%b expected 1 1", done, cpu_rstn);
    end
    check_drained("byte_wins");
  endtask

  task automatic test_sync_as_data();
`ifdef LOADER_ACK_EN
    int fired;
    tx_ready = 1'b0;
    repeat (2) tick();
`endif
    send_byte(8'h00);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL lead_ignore busy=%b expected 0", busy);
    end
    send_sync();
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(9'd0, 8'hA5, 8'hFF);
    send_byte(8'h00 - tsum);
    checks++;
    if (done !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL sync_as_data done=%b err=%b expected 1 0", done, err);
    end
    check_drained("sync_as_data");
`ifdef LOADER_ACK_EN
    fired = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (ack_start === 1'b1) fired++;
    end
    checks++;
    if (fired != 0) begin
      errors++;
      $display("FAIL ack_held got=%0d pulses expected=0", fired);
    end
    tx_ready = 1'b1;
    tick();
    checks++;
    if (ack_start !== 1'b1 || ack_data !== 8'h4B) begin
      errors++;
      $display("FAIL ack_send ack_start=%b ack_data=%0h expected 1 4b", ack_start, ack_data);
    end
    tick();
    checks++;
    if (ack_start !== 1'b0) begin
      errors++;
      $display("FAIL ack_pulse ack_start=%b expected 0", ack_start);
    end
`endif
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    cyc     = 0;
    tsum    = 8'h00;
    rstn    = 1'b0;
    rx_rcv  = 1'b0;
    rx_data = 8'h00;
`ifdef LOADER_ACK_EN
    tx_ready = 1'b1;
`endif
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_bad_len();
    test_max_words();
    test_timeout();
    test_byte_wins();
    test_sync_as_data();
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
